// File: rtl/lsu_if.sv
// Data-memory port between the load/store unit and memory:
// req/gnt address phase followed by an rvalid response phase.
interface lsu_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  data_req_o;
  logic                  data_gnt_i;
  logic [ADDR_WIDTH-1:0] data_addr_o;
  logic                  data_we_o;
  logic [3:0]            data_be_o;
  logic [DATA_WIDTH-1:0] data_wdata_o;
  logic                  data_rvalid_i;
  logic [DATA_WIDTH-1:0] data_rdata_i;

  modport master (
    output data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    input  data_gnt_i, data_rvalid_i, data_rdata_i
  );

  modport slave (
    input  data_req_o, data_addr_o, data_we_o, data_be_o, data_wdata_o,
    output data_gnt_i, data_rvalid_i, data_rdata_i
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one outstanding data-memory transaction at a time,
// with lane steering for stores and sign/zero extension for loads.
module lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  lsu_req_i,
  input  logic                  lsu_we_i,
  input  logic [1:0]            lsu_size_i,
  input  logic                  lsu_sign_ext_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic                  lsu_busy_o,
  output logic                  lsu_rvalid_o,
  output logic [DATA_WIDTH-1:0] lsu_rdata_o,
  output logic                  lsu_err_o,
  lsu_if.master                 dmem
);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE        = 2'b00,
    WAIT_GNT    = 2'b01,
    WAIT_RVALID = 2'b10
  } state_t;

  function automatic logic access_err(input logic [1:0] size, input logic [1:0] off);
    logic err;
    case (size)
      SIZE_BYTE: err = 1'b0;
      SIZE_HALF: err = off[0];
      SIZE_WORD: err = (off != 2'b00);
      default:   err = 1'b1;
    endcase
    return err;
  endfunction

  function automatic logic [3:0] calc_be(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    case (size)
      SIZE_BYTE: be = 4'b0001 << off;
      SIZE_HALF: be = 4'b0011 << off;
      SIZE_WORD: be = 4'b1111;
      default:   be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] wd);
    logic [31:0] res;
    case (size)
      SIZE_BYTE: res = {4{wd[7:0]}};
      SIZE_HALF: res = {2{wd[15:0]}};
      default:   res = wd;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] format_load(input logic [31:0] rd, input logic [1:0] size,
                                              input logic sx, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    b = rd[{off, 3'b000} +: 8];
    h = rd[{off[1], 4'b0000} +: 16];
    case (size)
      SIZE_BYTE: res = {{24{sx & b[7]}}, b};
      SIZE_HALF: res = {{16{sx & h[15]}}, h};
      default:   res = rd;
    endcase
    return res;
  endfunction

  state_t                r_state;
  state_t                w_next_state;
  logic                  w_accept;
  logic                  w_err;
  logic                  w_done;

  logic                  r_busy;
  logic                  r_req;
  logic                  r_rvalid;
  logic                  r_err;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [3:0]            r_be;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_we;
  logic [1:0]            r_size;
  logic                  r_sign;
  logic [1:0]            r_offset;

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic and per-cycle event strobes.
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_err        = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (lsu_req_i) begin
          if (access_err(lsu_size_i, addr_i[1:0])) begin
            w_err        = 1'b1;
            w_next_state = IDLE;
          end else begin
            w_accept     = 1'b1;
            w_next_state = WAIT_GNT;
          end
        end else begin
          w_next_state = IDLE;
        end
      end
      WAIT_GNT: begin
        if (dmem.data_gnt_i) begin
          w_next_state = WAIT_RVALID;
        end else begin
          w_next_state = WAIT_GNT;
        end
      end
      WAIT_RVALID: begin
        if (dmem.data_rvalid_i) begin
          w_done       = 1'b1;
          w_next_state = IDLE;
        end else begin
          w_next_state = WAIT_RVALID;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Output and transaction registers; status flags track the next state so they are registered.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_busy   <= 1'b0;
      r_req    <= 1'b0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= {DATA_WIDTH{1'b0}};
      r_addr   <= {ADDR_WIDTH{1'b0}};
      r_be     <= 4'b0000;
      r_wdata  <= {DATA_WIDTH{1'b0}};
      r_we     <= 1'b0;
      r_size   <= 2'b00;
      r_sign   <= 1'b0;
      r_offset <= 2'b00;
    end else begin
      r_busy   <= (w_next_state != IDLE);
      r_req    <= (w_next_state == WAIT_GNT);
      r_rvalid <= w_done;
      r_err    <= w_err;
      if (w_accept) begin
        r_addr   <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
        r_be     <= calc_be(lsu_size_i, addr_i[1:0]);
        r_wdata  <= replicate(lsu_size_i, wdata_i);
        r_we     <= lsu_we_i;
        r_size   <= lsu_size_i;
        r_sign   <= lsu_sign_ext_i;
        r_offset <= addr_i[1:0];
      end
      // Stores complete with zero data so writeback never sees stale bus contents.
      if (w_done) begin
        r_rdata <= r_we ? {DATA_WIDTH{1'b0}}
                        : format_load(dmem.data_rdata_i, r_size, r_sign, r_offset);
      end
    end
  end

  assign lsu_busy_o        = r_busy;
  assign lsu_rvalid_o      = r_rvalid;
  assign lsu_rdata_o       = r_rdata;
  assign lsu_err_o         = r_err;
  assign dmem.data_req_o   = r_req;
  assign dmem.data_addr_o  = r_addr;
  assign dmem.data_we_o    = r_we;
  assign dmem.data_be_o    = r_be;
  assign dmem.data_wdata_o = r_wdata;

endmodule
